// File: rtl/csr_desc_packer_pkg.sv
// Shared parameters, field offsets and FSM encoding for the CSR tile descriptor packer.
package csr_desc_packer_pkg;
  localparam int M          = 16;
  localparam int DW_MEM     = 512;
  localparam int DW_ROWIDX  = 4;
  localparam int DW_ELEIDX  = 8;
  localparam int DW_ROWPTR  = (M + 1) * DW_ELEIDX;
  localparam int DW_ROW2ROW = M * DW_ROWIDX;
  localparam int KW         = $clog2(M + 1);

  localparam int WKLD_START_OFF = DW_ROWPTR + DW_ROW2ROW;
  localparam int WKLD_END_OFF   = WKLD_START_OFF + DW_ROWIDX;
  localparam int DESC_USED      = WKLD_END_OFF + DW_ROWIDX;
  localparam bit DESC_FITS      = (DESC_USED <= DW_MEM);

  localparam logic [DW_ELEIDX-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    SCAN  = 2'd2,
    EMIT  = 2'd3
  } state_e;
endpackage

// File: rtl/csr_desc_packer_row_nnz_counter.sv
// Per-row nonzero counters plus a tile-wide total; all saturate at CNT_MAX.
module row_nnz_counter
  import csr_desc_packer_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     inc_i,
  input  logic [DW_ROWIDX-1:0]     row_i,
  input  logic                     clr_i,
  output logic [M*DW_ELEIDX-1:0]   cnt_o,
  output logic [DW_ELEIDX-1:0]     total_o
);
  logic [DW_ELEIDX-1:0] total_q;

  generate
    for (genvar gi = 0; gi < M; gi++) begin : g_row
      logic [DW_ELEIDX-1:0] cnt_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else if (clr_i) begin
          cnt_q <= '0;
        end else if (inc_i && row_i == DW_ROWIDX'(gi) && cnt_q != CNT_MAX) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
      assign cnt_o[gi*DW_ELEIDX +: DW_ELEIDX] = cnt_q;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_q <= '0;
    end else if (clr_i) begin
      total_q <= '0;
    end else if (inc_i && total_q != CNT_MAX) begin
      total_q <= total_q + 1'b1;
    end
  end

  assign total_o = total_q;
endmodule

// File: rtl/csr_desc_packer.sv
// Counts nonzeros per row of a tile, compacts empty rows and emits one packed
// row-pointer / row-map descriptor with a single-cycle write_en strobe.
module csr_desc_packer
  import csr_desc_packer_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW_ROWIDX-1:0] in_row,
  input  logic                 in_null,
  input  logic                 in_last,
  output logic                 write_en,
  output logic [DW_MEM-1:0]    cu_input,
  output logic                 err
);
  generate
    if (!DESC_FITS) begin : g_width_check
      $error("descriptor fields exceed DW_MEM");
    end
  endgenerate

  state_e                state_q;
  logic                  in_ready_q, write_en_q, err_q, seen_q;
  logic [DW_MEM-1:0]     cu_input_q;
  logic [DW_ROWIDX-1:0]  prev_row_q, scan_row_q;
  logic [KW-1:0]         k_q, k_d;
  logic [DW_ELEIDX-1:0]  acc_q, acc_d;
  logic [DW_ROWIDX-1:0]  row2row_q [M];
  logic [DW_ROWIDX-1:0]  row2row_d [M];
  logic [DW_ELEIDX-1:0]  row_ptrs_q [M+1];
  logic [DW_ELEIDX-1:0]  row_ptrs_d [M+1];

  logic [M*DW_ELEIDX-1:0] cnt_w;
  logic [DW_ELEIDX-1:0]   total_w, cur_cnt_w;
  logic [DW_MEM-1:0]      desc_d;
  logic accept_w, elem_w, full_w, inc_w, drop_w, order_bad_w, clr_w;

  assign accept_w    = in_valid & in_ready_q;
  assign elem_w      = accept_w & ~in_null;
  assign full_w      = (total_w == CNT_MAX);
  assign inc_w       = elem_w & ~full_w;
  assign drop_w      = elem_w & full_w;
  assign order_bad_w = elem_w & seen_q & (in_row < prev_row_q);
  assign clr_w       = (state_q == EMIT);

  row_nnz_counter u_cnt (
    .clk     (clk),
    .rst_n   (reset),
    .inc_i   (inc_w),
    .row_i   (in_row),
    .clr_i   (clr_w),
    .cnt_o   (cnt_w),
    .total_o (total_w)
  );

  assign cur_cnt_w = cnt_w[scan_row_q*DW_ELEIDX +: DW_ELEIDX];

  // One scan step; every pointer beyond the new k tracks the running sum so
  // unused tail entries end up equal to the final total.
  always_comb begin
    k_d        = k_q;
    acc_d      = acc_q;
    row2row_d  = row2row_q;
    row_ptrs_d = row_ptrs_q;
    if (cur_cnt_w != '0) begin
      acc_d = acc_q + cur_cnt_w;
      row2row_d[k_q[DW_ROWIDX-1:0]] = scan_row_q;
      for (int j = 1; j <= M; j++) begin
        if (KW'(j) > k_q) row_ptrs_d[j] = acc_d;
      end
      k_d = k_q + 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi <= M; gi++) begin : g_pack_ptr
      assign desc_d[gi*DW_ELEIDX +: DW_ELEIDX] = row_ptrs_d[gi];
    end
    for (genvar gi = 0; gi < M; gi++) begin : g_pack_map
      assign desc_d[DW_ROWPTR + gi*DW_ROWIDX +: DW_ROWIDX] = row2row_d[gi];
    end
  endgenerate
  assign desc_d[WKLD_START_OFF +: DW_ROWIDX] = '0;
  // k == M deliberately wraps to 0; the consumer compares against wkld_end-1.
  assign desc_d[WKLD_END_OFF +: DW_ROWIDX]   = k_d[DW_ROWIDX-1:0];
  assign desc_d[DW_MEM-1:DESC_USED]          = '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
      write_en_q <= 1'b0;
      err_q      <= 1'b0;
      seen_q     <= 1'b0;
      cu_input_q <= '0;
      prev_row_q <= '0;
      scan_row_q <= '0;
      k_q        <= '0;
      acc_q      <= '0;
      for (int i = 0; i < M; i++) row2row_q[i] <= '0;
      for (int i = 0; i <= M; i++) row_ptrs_q[i] <= '0;
    end else begin
      if (order_bad_w || drop_w) err_q <= 1'b1;
      case (state_q)
        IDLE, COUNT: begin
          in_ready_q <= 1'b1;
          if (accept_w) begin
            state_q <= COUNT;
            if (elem_w) begin
              seen_q     <= 1'b1;
              prev_row_q <= in_row;
            end
            if (in_last) begin
              state_q    <= SCAN;
              in_ready_q <= 1'b0;
              scan_row_q <= '0;
              k_q        <= '0;
              acc_q      <= '0;
              for (int i = 0; i < M; i++) row2row_q[i] <= '0;
              for (int i = 0; i <= M; i++) row_ptrs_q[i] <= '0;
            end
          end
        end
        SCAN: begin
          k_q        <= k_d;
          acc_q      <= acc_d;
          row2row_q  <= row2row_d;
          row_ptrs_q <= row_ptrs_d;
          scan_row_q <= scan_row_q + 1'b1;
          if (scan_row_q == DW_ROWIDX'(M - 1)) begin
            state_q    <= EMIT;
            write_en_q <= 1'b1;
            cu_input_q <= desc_d;
          end
        end
        EMIT: begin
          write_en_q <= 1'b0;
          in_ready_q <= 1'b1;
          seen_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign write_en = write_en_q;
  assign cu_input = cu_input_q;
  assign err      = err_q;
endmodule

// File: tb/tb_csr_desc_packer.sv
// Scoreboard bench: tiles push hand-built expected descriptors, a monitor checks each write_en.
module tb_csr_desc_packer;
  localparam int M = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   in_row = '0;
  logic         in_null = 1'b0;
  logic         in_last = 1'b0;
  logic         write_en;
  logic [511:0] cu_input;
  logic         err;

  csr_desc_packer dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_row   (in_row),
    .in_null  (in_null),
    .in_last  (in_last),
    .write_en (write_en),
    .cu_input (cu_input),
    .err      (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int emits = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [511:0] desc;
    logic         err;
    int           cyc;
  } exp_t;
  exp_t sb[$];

  logic [7:0] exp_rp  [17];
  logic [3:0] exp_r2r [16];
  logic [3:0] exp_wend;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Layout: row_ptrs at bit 0 (17x8), row2row at 136 (16x4), start at 200, end at 204.
  function automatic logic [511:0] mk_desc();
    logic [511:0] d = '0;
    for (int i = 0; i < 17; i++) d[i*8 +: 8] = exp_rp[i];
    for (int i = 0; i < 16; i++) d[136 + i*4 +: 4] = exp_r2r[i];
    d[204 +: 4] = exp_wend;
    return d;
  endfunction

  task automatic clear_exp();
    for (int i = 0; i < 17; i++) exp_rp[i] = 8'd0;
    for (int i = 0; i < 16; i++) exp_r2r[i] = 4'd0;
    exp_wend = 4'd0;
  endtask

  task automatic fill_rp(input int from, input logic [7:0] val);
    for (int i = from; i < 17; i++) exp_rp[i] = val;
  endtask

  task automatic push_exp(input logic e, input int c);
    exp_t x;
    x.desc = mk_desc();
    x.err  = e;
    x.cyc  = c;
    sb.push_back(x);
  endtask

  task automatic send(input logic [3:0] row, input logic nul, input logic last, output int emit_cyc);
    int waitc = 0;
    @(negedge clk);
    in_valid = 1'b1; in_row = row; in_null = nul; in_last = last;
    while (!in_ready && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL in_ready_timeout actual=0 required=1 cyc=%0d", cyc);
    end
    emit_cyc = cyc + 1 + M;
    @(posedge clk);
    #1 in_valid = 1'b0; in_last = 1'b0; in_null = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("drain_pending", 512'(sb.size()), 512'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_null = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 512'(in_ready), 512'd0);
    chk("rst_write_en", 512'(write_en), 512'd0);
    chk("rst_cu_input", cu_input, 512'd0);
    chk("rst_err", 512'(err), 512'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 512'(in_ready), 512'd1);
  endtask

  always @(negedge clk) begin
    if (write_en) begin
      emits++;
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_write_en actual=1 required=0 cyc=%0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("emit %0d cyc=%0d wkld_end=%0d err=%0b", emits, cyc, cu_input[204 +: 4], err);
        chk("descriptor", cu_input, e.desc);
        chk("err_at_emit", 512'(err), 512'(e.err));
        chk("emit_cycle", 512'(cyc), 512'(e.cyc));
        chk("in_ready_during_emit", 512'(in_ready), 512'd0);
      end
    end
  end

  initial begin
    int ec;
    int rows1[6] = '{0, 0, 1, 3, 3, 3};
    apply_reset();

    // Rows 0,0,1,3,3,3
    clear_exp();
    exp_rp[1] = 8'd2; exp_rp[2] = 8'd3; fill_rp(3, 8'd6);
    exp_r2r[0] = 4'd0; exp_r2r[1] = 4'd1; exp_r2r[2] = 4'd3; exp_wend = 4'd3;
    for (int i = 0; i < 6; i++) send(4'(rows1[i]), 1'b0, i == 5, ec);
    push_exp(1'b0, ec);

    // Empty tile: one null beat with last
    clear_exp();
    send(4'd0, 1'b1, 1'b1, ec);
    push_exp(1'b0, ec);

    // One element in every row: k = 16 wraps wkld_end to 0
    clear_exp();
    for (int i = 0; i < 17; i++) exp_rp[i] = 8'(i);
    for (int i = 0; i < 16; i++) exp_r2r[i] = 4'(i);
    exp_wend = 4'd0;
    for (int r = 0; r < 16; r++) send(4'(r), 1'b0, r == 15, ec);
    push_exp(1'b0, ec);
    wait_drain();
    chk("err_clean", 512'(err), 512'd0);

    // Ordering violation: rows 4 then 2
    clear_exp();
    exp_rp[1] = 8'd1; fill_rp(2, 8'd2);
    exp_r2r[0] = 4'd2; exp_r2r[1] = 4'd4; exp_wend = 4'd2;
    send(4'd4, 1'b0, 1'b0, ec);
    send(4'd2, 1'b0, 1'b1, ec);
    push_exp(1'b1, ec);
    wait_drain();

    apply_reset();

    // Capacity saturation: 300 elements on row 5
    clear_exp();
    fill_rp(1, 8'd255);
    exp_r2r[0] = 4'd5; exp_wend = 4'd1;
    for (int i = 0; i < 300; i++) send(4'd5, 1'b0, i == 299, ec);
    push_exp(1'b1, ec);
    wait_drain();

    // Reset mid-tile discards partial counts; then rows 7,7
    send(4'd1, 1'b0, 1'b0, ec);
    send(4'd2, 1'b0, 1'b0, ec);
    send(4'd3, 1'b0, 1'b0, ec);
    apply_reset();
    clear_exp();
    fill_rp(1, 8'd2);
    exp_r2r[0] = 4'd7; exp_wend = 4'd1;
    send(4'd7, 1'b0, 1'b0, ec);
    send(4'd7, 1'b0, 1'b1, ec);
    push_exp(1'b0, ec);
    wait_drain();
    chk("emit_count", 512'(emits), 512'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
